// File: rtl/scoreboard_register_file.sv
// -----------------------------------------------------------------------------
// scoreboard_register_file
//
// Parametrised general-purpose register file for the pipelined datapath.
// It has two combinational read ports and one writeback port. Other features:
//   - an optional hardwired zero register (register 0),
//   - an optional write-to-read bypass,
//   - a per-register pending bit, so decode can detect RAW and WAW hazards
//     against writebacks that are still in flight.
//
// After reset a clearing sweep zeroes one register per cycle. Because of this
// the storage array needs no reset and can map to distributed RAM.
//
// Parameters
//   DATA_WIDTH  register width in bits
//   ADDR_WIDTH  register address width; DEPTH = 2**ADDR_WIDTH
//   ZERO_REG    1: register 0 reads as 0, ignores writes and is never pending
//   BYPASS      1: writeback data forwards combinationally to the read ports
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous active-high reset
//   ready           clearing sweep complete
//   rs_addr/rt_addr read port A/B addresses
//   rs/rt           read port A/B data (combinational)
//   rs_busy/rt_busy register at rs_addr/rt_addr is pending
//   issue           mark issue_addr pending (instruction dispatched)
//   issue_addr      destination of the dispatched instruction
//   issue_conflict  issue to an already-pending register (WAW)
//   write           writeback strobe
//   rd_addr         writeback address
//   data_in         writeback data
// -----------------------------------------------------------------------------
module scoreboard_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ready,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    output logic [DATA_WIDTH-1:0] rs,
    output logic [DATA_WIDTH-1:0] rt,
    output logic                  rs_busy,
    output logic                  rt_busy,
    input  logic                  issue,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic                  issue_conflict,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] data_in
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam bit ZERO_EN   = (ZERO_REG != 0);
    localparam bit BYPASS_EN = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      pending_next;
    logic [ADDR_WIDTH-1:0] sweep_ptr;

    logic wr_en;
    logic iss_req;
    logic byp_rs;
    logic byp_rt;

    // A qualified writeback or issue requires a finished sweep and a
    // non-zero target when register 0 is hardwired.
    assign wr_en   = ready && write && !(ZERO_EN && rd_addr == '0);
    assign iss_req = ready && issue && !(ZERO_EN && issue_addr == '0);

    assign byp_rs = BYPASS_EN && wr_en && (rd_addr == rs_addr);
    assign byp_rt = BYPASS_EN && wr_en && (rd_addr == rt_addr);

    // The writeback is applied before the issue. So an issue to the register
    // that is being written in the same cycle sees it free, and ends pending.
    assign issue_conflict = iss_req && pending[issue_addr]
                            && !(wr_en && rd_addr == issue_addr);

    always_comb begin
        // NOTE: start from a full default so no path leaves pending_next
        // unassigned; otherwise the tool infers a latch.
        pending_next = pending;
        if (wr_en) begin
            pending_next[rd_addr] = 1'b0;
        end
        if (iss_req) begin
            pending_next[issue_addr] = 1'b1;
        end
    end

    // Control state: sweep pointer, ready flag and scoreboard bits.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop
        // then samples the pre-edge values, with no ordering races.
        if (reset) begin
            sweep_ptr <= '0;
            pending   <= '0;
            ready     <= 1'b0;
        end else if (!ready) begin
            sweep_ptr <= sweep_ptr + 1'b1;
            if (sweep_ptr == LAST_ADDR) begin
                ready <= 1'b1;
            end
        end else begin
            pending <= pending_next;
        end
    end

    // Storage array.
    // NOTE: the array is deliberately left out of the reset branch so it can
    // map to RAM. It is zeroed by the post-reset sweep instead, and the read
    // ports are forced to 0 until that sweep completes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (!ready) begin
                mem[sweep_ptr] <= '0;
            end else if (wr_en) begin
                mem[rd_addr] <= data_in;
            end
        end
    end

    // Read ports: bypass takes priority, then the zero register, then storage.
    always_comb begin
        rs      = '0;
        rt      = '0;
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        if (ready) begin
            if (byp_rs) begin
                rs = data_in;
            end else if (!(ZERO_EN && rs_addr == '0)) begin
                rs = mem[rs_addr];
            end

            if (byp_rt) begin
                rt = data_in;
            end else if (!(ZERO_EN && rt_addr == '0)) begin
                rt = mem[rt_addr];
            end

            rs_busy = pending[rs_addr] && !byp_rs;
            rt_busy = pending[rt_addr] && !byp_rt;
        end
    end

endmodule
